// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the ALU command sequencer.
// Opcode and FSM encodings used by the sequencer, its FIFO and benches.
package alu_seq_pkg;

    localparam int ALU_DATA_W = 4;
    localparam int ALU_OP_W   = 3;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b010,
        OR  = 3'b011,
        XOR = 3'b100,
        SHL = 3'b101,
        SHR = 3'b110,
        GT  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO for the ALU sequencer.
// Push is ignored when full and pop when empty; pointers wrap mod DEPTH.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int W     = 2 * ALU_DATA_W + ALU_OP_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wr_data,
    input  logic                       pop,
    output logic [W-1:0]               rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives each onto the ALU for one cycle and
// returns captured result/zero in order on a valid/ready stream.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DATA_W-1:0]          cmd_a,
    input  logic [DATA_W-1:0]          cmd_b,
    input  logic [OP_W-1:0]            cmd_op,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_op,
    output logic                       alu_rst,
    input  logic [DATA_W-1:0]          alu_result,
    input  logic                       alu_zero,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic                       rsp_zero,
    output logic [OP_W-1:0]            rsp_op,
    output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

    localparam int FW = 2 * DATA_W + OP_W;

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] drv_a_q, drv_a_d;
    logic [DATA_W-1:0] drv_b_q, drv_b_d;
    logic [OP_W-1:0]   drv_op_q, drv_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic [OP_W-1:0]   rsp_op_q, rsp_op_d;

    logic              fifo_full, fifo_empty, pop;
    logic [FW-1:0]     head;
    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;

    // Ready depends only on the registered fill level.
    assign cmd_ready = !fifo_full;
    assign {head_a, head_b, head_op} = head;

    alu_cmd_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (cmd_valid && cmd_ready),
        .wr_data ({cmd_a, cmd_b, cmd_op}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (cmd_count)
    );

    always_comb begin
        state_d      = state_q;
        drv_a_d      = drv_a_q;
        drv_b_d      = drv_b_q;
        drv_op_d     = drv_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_op_d     = rsp_op_q;
        pop          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                rsp_valid_d  = 1'b1;
                rsp_result_d = alu_result;
                rsp_zero_d   = alu_zero;
                rsp_op_d     = drv_op_q;
                state_d      = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            drv_a_d  = head_a;
            drv_b_d  = head_b;
            drv_op_d = head_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drv_a_q      <= '0;
            drv_b_q      <= '0;
            drv_op_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_op_q     <= '0;
        end else begin
            state_q      <= state_d;
            drv_a_q      <= drv_a_d;
            drv_b_q      <= drv_b_d;
            drv_op_q     <= drv_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_op_q     <= rsp_op_d;
        end
    end

    assign alu_a      = drv_a_q;
    assign alu_b      = drv_b_q;
    assign alu_op     = drv_op_q;
    assign alu_rst    = (state_q != DRIVE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_op     = rsp_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU.
// Directed commands push expected responses; a monitor pops and compares.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    typedef struct {
        logic [3:0] res;
        logic       z;
        logic [2:0] op;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_rst, alu_zero;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result;
    logic       rsp_zero;
    logic [2:0] rsp_op;
    logic [2:0] cmd_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t sb[$];
    int   hs_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_rst    (alu_rst),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_op     (rsp_op),
        .cmd_count  (cmd_count)
    );

    // Reference combinational ALU attached to the sequencer.
    always_comb begin
        alu_result = 4'd0;
        case (alu_op)
            ADD: alu_result = alu_a + alu_b;
            SUB: alu_result = alu_a - alu_b;
            AND: alu_result = alu_a & alu_b;
            OR:  alu_result = alu_a | alu_b;
            XOR: alu_result = alu_a ^ alu_b;
            SHL: alu_result = alu_a << alu_b;
            SHR: alu_result = alu_a >> alu_b;
            GT:  alu_result = (alu_a > alu_b) ? 4'd1 : 4'd0;
            default: alu_result = 4'd0;
        endcase
        if (alu_rst) alu_result = 4'd0;
        alu_zero = (alu_result == 4'd0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [3:0] er,
                        input logic ez);
        bit ok = 0;
        int n = 0;
        exp_t e;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        while (!ok && n < 200) begin
            ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (ok) begin
            e.res = er;
            e.z = ez;
            e.op = op;
            sb.push_back(e);
        end else begin
            chk("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    // Monitor: compares responses and checks stability under backpressure.
    initial begin
        bit         stall = 0;
        logic [3:0] h_res;
        logic       h_z;
        logic [2:0] h_op;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall = 0;
            end else begin
                if (stall) begin
                    chk("hold_valid", rsp_valid, 1);
                    chk("hold_result", rsp_result, h_res);
                    chk("hold_zero", rsp_zero, h_z);
                    chk("hold_op", rsp_op, h_op);
                end
                if (rsp_valid && rsp_ready) begin
                    hs_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        chk("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_result", rsp_result, e.res);
                        chk("rsp_zero", rsp_zero, e.z);
                        chk("rsp_op", rsp_op, e.op);
                    end
                end
                stall = rsp_valid && !rsp_ready;
                h_res = rsp_result;
                h_z = rsp_zero;
                h_op = rsp_op;
            end
        end
    end

    initial begin
        bit done;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_op = '0;
        rsp_ready = 1'b0;

        // Reset values held while reset stays low
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_alu_rst", alu_rst, 1);
            chk("rst_alu_abop", {alu_a, alu_b, alu_op}, 0);
            chk("rst_cmd_count", cmd_count, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_cmd_ready", cmd_ready, 1);

        // Single ADD latency
        rsp_ready = 1'b1;
        send(4'd3, 4'd4, ADD, 4'd7, 1'b0);
        chk("lat_e0_alu_rst", alu_rst, 1);
        chk("lat_e0_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_e1_alu_rst", alu_rst, 0);
        chk("lat_e1_drive", {alu_a, alu_b, alu_op}, {4'd3, 4'd4, 3'b000});
        chk("lat_e1_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        chk("lat_e2_alu_rst", alu_rst, 1);
        chk("lat_e2_valid", rsp_valid, 1);
        drain();

        // Boundary operations
        send(4'd15, 4'd1, ADD, 4'd0, 1'b1);
        send(4'd5, 4'd5, SUB, 4'd0, 1'b1);
        send(4'd2, 4'd9, GT, 4'd0, 1'b1);
        send(4'd9, 4'd2, GT, 4'd1, 1'b0);
        send(4'd1, 4'd3, SHL, 4'd8, 1'b0);
        drain();

        // Capacity with response stalled
        rsp_ready = 1'b0;
        send(4'd1, 4'd1, ADD, 4'd2, 1'b0);
        send(4'd2, 4'd2, ADD, 4'd4, 1'b0);
        send(4'd3, 4'd3, ADD, 4'd6, 1'b0);
        send(4'd15, 4'd0, XOR, 4'd15, 1'b0);
        send(4'd0, 4'd0, OR, 4'd0, 1'b1);
        cmd_valid = 1'b1;
        cmd_a = 4'd1;
        cmd_b = 4'd1;
        cmd_op = AND;
        for (int i = 0; i < 3; i++) begin
            chk("cap_cmd_ready", cmd_ready, 0);
            chk("cap_cmd_count", cmd_count, 4);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        hs_cyc.delete();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("cap_ready_after_pop", cmd_ready, 1);
        chk("cap_count_after_pop", cmd_count, 3);
        drain();
        chk("tput_n", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++) begin
            chk("tput_gap", hs_cyc[i] - hs_cyc[i-1], 2);
        end

        // Random backpressure
        done = 0;
        fork
            begin
                send(4'd12, 4'd10, AND, 4'd8, 1'b0);
                send(4'd5, 4'd2, OR, 4'd7, 1'b0);
                send(4'd9, 4'd9, XOR, 4'd0, 1'b1);
                send(4'd8, 4'd2, SHR, 4'd2, 1'b0);
                send(4'd2, 4'd3, SUB, 4'd15, 1'b0);
                send(4'd7, 4'd8, ADD, 4'd15, 1'b0);
                done = 1;
            end
            begin
                for (int k = 0; k < 400 && !done; k++) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rsp_ready = 1'b1;
        drain();

        // Reset during DRIVE with 3 commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'd1, 4'd2, ADD, 4'd3, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("mid_alu_rst", alu_rst, 0);
        chk("mid_cmd_count", cmd_count, 3);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("async_alu_rst", alu_rst, 1);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_cmd_count", cmd_count, 0);
        chk("async_alu_abop", {alu_a, alu_b, alu_op}, 0);
        chk("async_rsp_regs", {rsp_result, rsp_zero, rsp_op}, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        send(4'd9, 4'd4, SUB, 4'd5, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Initiator-side front end for the team's combinational 4-bit ALU. It accepts operation commands over a valid/ready stream and queues them in a small FIFO. It drives each command onto the ALU's a/b/op/rst inputs for exactly one cycle, captures result/zero, and returns them in order on a valid/ready response stream. It sits between a command producer (bench sequencer or control FSM) and the ALU instance.

Parameters:
DATA_W, 4, operand and result width; must match the ALU.
OP_W, 3, opcode width.
DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge
cmd_a  input  DATA_W  operand a
cmd_b  input  DATA_W  operand b
cmd_op  input  OP_W  opcode
alu_a  output  DATA_W  to ALU a
alu_b  output  DATA_W  to ALU b
alu_op  output  OP_W  to ALU op
alu_rst  output  1  to ALU rst (active-high); forces ALU result to 0 when not driving
alu_result  input  DATA_W  from ALU result
alu_zero  input  1  from ALU zero
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready at a rising edge
rsp_result  output  DATA_W  captured ALU result
rsp_zero  output  1  captured ALU zero flag
rsp_op  output  OP_W  opcode of the command that produced this response
cmd_count  output  $clog2(DEPTH+1)  entries currently in the FIFO

Behaviour:
- Reset (rst_n low, asynchronous): FIFO emptied, pointers and cmd_count 0, state IDLE, drive registers 0, alu_rst=1, rsp_valid=0, response registers 0, cmd_ready=1 once rst_n is released.
- cmd_ready = (cmd_count != DEPTH). It is registered-state based only, with no combinational path from rsp_ready or from the pop.
- Simultaneous push and pop updates the FIFO and leaves cmd_count unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the drive registers and go to DRIVE; else stay in IDLE.
  - DRIVE: alu_rst=0; alu_a/b/op show the popped command. On the closing edge, capture alu_result, alu_zero and op into the response registers, set rsp_valid=1, and go to HOLD. DRIVE lasts exactly one cycle.
  - HOLD: alu_rst=1; rsp_* are held stable while rsp_valid & !rsp_ready. On the handshake edge, clear rsp_valid. If the FIFO is non-empty on that edge, also pop the next command and go to DRIVE; else go to IDLE.
- Drive registers keep their last value outside DRIVE. Only alu_rst distinguishes an active cycle.
- Latency: command accepted at edge E0 into an empty, idle block gives DRIVE during E1..E2 and rsp_valid=1 from E2 (2 cycles).
- Peak throughput: one response per 2 cycles.
- Order: responses are returned strictly in command order; no command is dropped or duplicated.
- Capacity: with rsp_ready held low, DEPTH+1 commands are accepted (1 held in the response registers, DEPTH in the FIFO).
- Arithmetic is performed entirely by the external ALU. The block never modifies alu_result or alu_zero; wrap-around and shift overflow are whatever the ALU returns.
- Reset mid-operation discards all queued and in-flight commands. No response appears after release until a new command is accepted.

Decomposition:
- Package alu_seq_pkg:
  - DATA_W and OP_W default constants.
  - Opcode enum: ADD=000, SUB=001, AND=010, OR=011, XOR=100, SHL=101, SHR=110, GT=111.
  - FSM state enum: IDLE, DRIVE, HOLD.
- Sub-module alu_cmd_fifo: synchronous FIFO, width DATA_W*2+OP_W, depth DEPTH; push/pop/full/empty/count; same clk and rst_n.

Test Plan:
1. rst_n=0 -> cmd_ready=1, rsp_valid=0, alu_rst=1, alu_a/b/op=0, cmd_count=0; all hold while rst_n stays low.
2. With the ALU attached, rsp_ready=1, single ADD a=3 b=4 -> alu_rst low for exactly 1 cycle; rsp_valid 2 cycles after accept; rsp_result=7, rsp_zero=0, rsp_op=000.
3. Boundary ops -> expected responses:
   - ADD 15+1 -> result 0, zero=1.
   - SUB 5-5 -> result 0, zero=1.
   - GT 2,9 -> result 0, zero=1.
   - GT 9,2 -> result 1, zero=0.
   - SHL 1,3 -> result 8.
4. rsp_ready=0, cmd_valid held with 6 distinct commands -> exactly 5 accepted; cmd_ready low with cmd_count=4. Then rsp_ready=1 -> 5 responses in order, one every 2 cycles; cmd_ready returns high after the first pop.
5. Backpressure: rsp_ready toggled randomly -> rsp_result/zero/op unchanged while rsp_valid & !rsp_ready; no lost or repeated responses.
6. Assert rst_n during DRIVE with 3 commands queued -> all outputs take reset values immediately (asynchronously); after release no rsp_valid occurs until a new command is sent.
